menu_nav_engine: RTL and testbench
==================================

Name: menu_nav_engine

Overview:
Parametrised multi-level menu navigator, successor to the flat page/item menu controller. Tracks the current page and item, and supports variable item counts per page. Select on an item that owns a child page descends into it; back returns via a hardware return stack. Sits behind the AXI button-pulse wrapper and feeds menu state to the LCD/display path, with an optional inactivity timeout that returns to the root page.

Parameters:
NUM_PAGES, 8, total page count (root and child pages share one page index space)
PAGE_WIDTH, 3, page index width; 2^PAGE_WIDTH >= NUM_PAGES
MAX_ITEMS, 8, upper bound on items per page
ITEM_WIDTH, 3, item index width; 2^ITEM_WIDTH >= MAX_ITEMS
STACK_DEPTH, 4, maximum nesting depth (return-stack entries)
DEPTH_WIDTH, 3, depth counter width; must hold 0..STACK_DEPTH
WRAP_EN, 1, 1 = up/down/left/right wrap around; 0 = clamp at ends
TIMEOUT_CYCLES, 0, idle cycles before auto-return to root; 0 disables the timeout
TO_WIDTH, 32, timeout counter width

Ports:
clk  in  1  system clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
btn_up  in  1  1-cycle pulse: previous item
btn_down  in  1  1-cycle pulse: next item
btn_left  in  1  1-cycle pulse: previous page (depth 0 only)
btn_right  in  1  1-cycle pulse: next page (depth 0 only)
btn_select  in  1  1-cycle pulse: select current item
btn_back  in  1  1-cycle pulse: return to parent page
item_count_i  in  ITEM_WIDTH+1  item count of current_page, from an external table indexed combinationally by current_page
child_en_i  in  1  current {current_page,current_item} owns a child page
child_page_i  in  PAGE_WIDTH  child page index, valid when child_en_i=1
current_page  out  PAGE_WIDTH  registered page index
current_item  out  ITEM_WIDTH  registered item index
depth  out  DEPTH_WIDTH  current nesting level, 0 = root
selected_id  out  PAGE_WIDTH+ITEM_WIDTH  {page,item} of the last leaf select
item_selected  out  1  1-cycle pulse on leaf select
stack_overflow  out  1  1-cycle pulse: descent refused because the stack is full
timeout_evt  out  1  1-cycle pulse: inactivity return to root

Behaviour:
- Reset, asynchronous and active-low: current_page=0, current_item=0, depth=0, selected_id=0, all pulses=0, stack cleared, idle counter=0.
- Latency: a button sampled high at edge N is reflected in the outputs after edge N; all outputs are registered.
- Effective count C = item_count_i clamped to 1..MAX_ITEMS; an input value of 0 is treated as 1.
- Priority when several buttons are high in one cycle: back > select > up > down > left > right. Only the winning button acts.
- up at item 0: goes to C-1 if WRAP_EN=1, otherwise stays at 0. Otherwise item-1.
- down at item >= C-1: goes to 0 if WRAP_EN=1, otherwise stays at C-1. Otherwise item+1.
- left/right: act only when depth=0.
  - Page steps -1/+1 over 0..NUM_PAGES-1, wrapping or clamping per WRAP_EN.
  - Item resets to 0.
  - Ignored when depth>0.
- select with child_en_i=0 (leaf): selected_id <= {current_page,current_item}; item_selected=1 for one cycle; page and item are unchanged.
- select with child_en_i=1 and depth<STACK_DEPTH (descend):
  - Push {current_page,current_item} onto the stack.
  - page <= child_page_i, item <= 0, depth+1.
  - No item_selected pulse.
- select with child_en_i=1 and depth=STACK_DEPTH: no state change; stack_overflow=1 for one cycle.
- back with depth>0: pop the stack and restore both page and item from the popped entry; depth-1.
- back with depth=0: ignored; no pulse.
- Idle counter:
  - Clears on any button high.
  - Otherwise increments while TIMEOUT_CYCLES>0 and the state is not already the root state (depth=0, page=0, item=0).
  - On reaching TIMEOUT_CYCLES-1: page=0, item=0, depth=0, stack emptied, timeout_evt=1 for one cycle, counter cleared.
  - A button arriving in the same cycle as the timeout wins; no timeout fires that cycle.
- item_count_i shrinking below current_item+1 without a button press: item is not altered until the next up/down. down then lands on C-1 (clamp) or 0 (wrap).
- Reset mid-descent or mid-timeout: returns immediately to the reset state; no pulses are emitted.

Test Plan:
- Reset, then item_count_i=5, WRAP_EN=1; down x5 -> items 1,2,3,4,0; then up -> 4.
- WRAP_EN=0, C=3: down x4 -> items 1,2,2,2; left at page 0 -> page stays 0.
- Page 2, item 1, child_en_i=1, child_page_i=6; select -> page 6, item 0, depth 1, no item_selected. Then down, down, back -> page 2, item 1, depth 0.
- Leaf select at page 3, item 2 (ITEM_WIDTH=3) -> selected_id=0x1A, item_selected high for exactly one cycle.
- Descend STACK_DEPTH=4 times, then a fifth child select -> stack_overflow pulse, depth stays 4. Back at depth 0 -> no change.
- TIMEOUT_CYCLES=10 at depth 2 with no buttons -> timeout_evt on the 10th idle cycle, outputs 0/0/0. Repeat with btn_select and btn_down high in the same cycle -> only the select acts. Assert rst_n low mid-run -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/menu_nav_engine.sv
// Multi-level menu navigator: page/item cursor with a return stack
// for child pages and an optional inactivity return to the root.
module menu_nav_engine #(
  parameter int NUM_PAGES      = 8,
  parameter int PAGE_WIDTH     = 3,
  parameter int MAX_ITEMS      = 8,
  parameter int ITEM_WIDTH     = 3,
  parameter int STACK_DEPTH    = 4,
  parameter int DEPTH_WIDTH    = 3,
  parameter bit WRAP_EN        = 1'b1,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TO_WIDTH       = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             btn_up,
  input  logic                             btn_down,
  input  logic                             btn_left,
  input  logic                             btn_right,
  input  logic                             btn_select,
  input  logic                             btn_back,
  input  logic [ITEM_WIDTH:0]              item_count_i,
  input  logic                             child_en_i,
  input  logic [PAGE_WIDTH-1:0]            child_page_i,
  output logic [PAGE_WIDTH-1:0]            current_page,
  output logic [ITEM_WIDTH-1:0]            current_item,
  output logic [DEPTH_WIDTH-1:0]           depth,
  output logic [PAGE_WIDTH+ITEM_WIDTH-1:0] selected_id,
  output logic                             item_selected,
  output logic                             stack_overflow,
  output logic                             timeout_evt
);

  localparam int SW = PAGE_WIDTH + ITEM_WIDTH;
  localparam logic [ITEM_WIDTH:0] MAXI =
    (ITEM_WIDTH+1)'(MAX_ITEMS);
  localparam logic [PAGE_WIDTH-1:0] PLAST =
    PAGE_WIDTH'(NUM_PAGES - 1);
  localparam logic [DEPTH_WIDTH-1:0] DFULL =
    DEPTH_WIDTH'(STACK_DEPTH);

  logic [PAGE_WIDTH-1:0]  page_q, page_d;
  logic [ITEM_WIDTH-1:0]  item_q, item_d;
  logic [DEPTH_WIDTH-1:0] depth_q, depth_d;
  logic [SW-1:0]          sid_q, sid_d;
  logic                   isel_q, isel_d;
  logic                   ovf_q, ovf_d;
  logic                   tevt_q, tevt_d;
  logic [TO_WIDTH-1:0]    idle_q, idle_d;
  logic [SW-1:0]          stk_q [STACK_DEPTH];
  logic [SW-1:0]          stk_d [STACK_DEPTH];

  logic [ITEM_WIDTH:0]   cnt_eff;
  logic [ITEM_WIDTH-1:0] last;
  logic [SW-1:0]         top;
  logic                  any_btn;
  logic                  at_root;

  // Effective item count (1..MAX_ITEMS) and last valid item index
  always_comb begin
    cnt_eff = item_count_i;
    if (item_count_i == '0) cnt_eff = (ITEM_WIDTH+1)'(1);
    else if (item_count_i > MAXI) cnt_eff = MAXI;
    last = ITEM_WIDTH'(cnt_eff - (ITEM_WIDTH+1)'(1));
  end

  // Top-of-stack entry, selected without a variable array index
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (depth_q == DEPTH_WIDTH'(i + 1)) top = stk_q[i];
    end
  end

  assign any_btn = btn_up | btn_down | btn_left | btn_right |
                   btn_select | btn_back;
  assign at_root = (depth_q == '0) && (page_q == '0) &&
                   (item_q == '0);

  // Next-state: prioritised button decode, then idle timeout
  always_comb begin
    page_d  = page_q;
    item_d  = item_q;
    depth_d = depth_q;
    sid_d   = sid_q;
    isel_d  = 1'b0;
    ovf_d   = 1'b0;
    tevt_d  = 1'b0;
    idle_d  = idle_q;
    stk_d   = stk_q;
    if (any_btn) idle_d = '0;
    if (btn_back) begin
      if (depth_q != '0) begin
        page_d  = top[SW-1:ITEM_WIDTH];
        item_d  = top[ITEM_WIDTH-1:0];
        depth_d = depth_q - DEPTH_WIDTH'(1);
      end
    end else if (btn_select) begin
      if (!child_en_i) begin
        sid_d  = {page_q, item_q};
        isel_d = 1'b1;
      end else if (depth_q < DFULL) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
          if (depth_q == DEPTH_WIDTH'(i)) stk_d[i] = {page_q, item_q};
        end
        page_d  = child_page_i;
        item_d  = '0;
        depth_d = depth_q + DEPTH_WIDTH'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (btn_up) begin
      if (item_q == '0) item_d = WRAP_EN ? last : '0;
      else item_d = item_q - ITEM_WIDTH'(1);
    end else if (btn_down) begin
      if (item_q >= last) item_d = WRAP_EN ? '0 : last;
      else item_d = item_q + ITEM_WIDTH'(1);
    end else if (btn_left) begin
      if (depth_q == '0) begin
        if (page_q == '0) page_d = WRAP_EN ? PLAST : '0;
        else page_d = page_q - PAGE_WIDTH'(1);
        item_d = '0;
      end
    end else if (btn_right) begin
      if (depth_q == '0) begin
        if (page_q >= PLAST) page_d = WRAP_EN ? '0 : PLAST;
        else page_d = page_q + PAGE_WIDTH'(1);
        item_d = '0;
      end
    end else if ((TIMEOUT_CYCLES > 0) && !at_root) begin
      if (idle_q == TO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
        page_d  = '0;
        item_d  = '0;
        depth_d = '0;
        tevt_d  = 1'b1;
        idle_d  = '0;
        for (int i = 0; i < STACK_DEPTH; i++) stk_d[i] = '0;
      end else begin
        idle_d = idle_q + TO_WIDTH'(1);
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page_q  <= '0;
      item_q  <= '0;
      depth_q <= '0;
      sid_q   <= '0;
      isel_q  <= 1'b0;
      ovf_q   <= 1'b0;
      tevt_q  <= 1'b0;
      idle_q  <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
    end else begin
      page_q  <= page_d;
      item_q  <= item_d;
      depth_q <= depth_d;
      sid_q   <= sid_d;
      isel_q  <= isel_d;
      ovf_q   <= ovf_d;
      tevt_q  <= tevt_d;
      idle_q  <= idle_d;
      for (int i = 0; i < STACK_DEPTH; i++) stk_q[i] <= stk_d[i];
    end
  end

  assign current_page   = page_q;
  assign current_item   = item_q;
  assign depth          = depth_q;
  assign selected_id    = sid_q;
  assign item_selected  = isel_q;
  assign stack_overflow = ovf_q;
  assign timeout_evt    = tevt_q;

endmodule

// File: tb/tb_menu_nav_engine.sv
// Directed bench: wrapping/timeout instance plus clamping instance,
// both driven from the same button and table inputs.
module tb_menu_nav_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic b_up = 0, b_down = 0, b_left = 0, b_right = 0;
  logic b_sel = 0, b_back = 0;
  logic [3:0] cnt = 4'd1;
  logic ch_en = 1'b0;
  logic [2:0] ch_pg = 3'd0;

  logic [2:0] w_page, c_page;
  logic [2:0] w_item, c_item;
  logic [2:0] w_depth, c_depth;
  logic [5:0] w_sid, c_sid;
  logic w_isel, w_ovf, w_tevt;
  logic c_isel, c_ovf, c_tevt;

  int cmp = 0;
  int err = 0;

  localparam logic [5:0] BACK = 6'b100000;
  localparam logic [5:0] SEL  = 6'b010000;
  localparam logic [5:0] UP   = 6'b001000;
  localparam logic [5:0] DOWN = 6'b000100;
  localparam logic [5:0] LEFT = 6'b000010;
  localparam logic [5:0] RGHT = 6'b000001;

  always #5 clk = ~clk;

  menu_nav_engine #(
    .WRAP_EN(1'b1), .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(b_up), .btn_down(b_down),
    .btn_left(b_left), .btn_right(b_right),
    .btn_select(b_sel), .btn_back(b_back),
    .item_count_i(cnt), .child_en_i(ch_en),
    .child_page_i(ch_pg),
    .current_page(w_page), .current_item(w_item),
    .depth(w_depth), .selected_id(w_sid),
    .item_selected(w_isel), .stack_overflow(w_ovf),
    .timeout_evt(w_tevt)
  );

  menu_nav_engine #(
    .WRAP_EN(1'b0), .TIMEOUT_CYCLES(0)
  ) dut_c (
    .clk(clk), .rst_n(rst_n),
    .btn_up(b_up), .btn_down(b_down),
    .btn_left(b_left), .btn_right(b_right),
    .btn_select(b_sel), .btn_back(b_back),
    .item_count_i(cnt), .child_en_i(ch_en),
    .child_page_i(ch_pg),
    .current_page(c_page), .current_item(c_item),
    .depth(c_depth), .selected_id(c_sid),
    .item_selected(c_isel), .stack_overflow(c_ovf),
    .timeout_evt(c_tevt)
  );

  task automatic press(input logic [5:0] b);
    @(negedge clk);
    {b_back, b_sel, b_up, b_down, b_left, b_right} = b;
    @(negedge clk);
    {b_back, b_sel, b_up, b_down, b_left, b_right} = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ch_en = 1'b0;
    ch_pg = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    cmp++;
    if ({w_page, w_item, w_depth, w_sid} !== 15'd0) begin
      err++;
      $display("FAIL reset_w got %h want 0",
               {w_page, w_item, w_depth, w_sid});
    end
    cmp++;
    if ({w_isel, w_ovf, w_tevt, c_isel, c_ovf, c_tevt} !== 6'd0) begin
      err++;
      $display("FAIL reset_pulses got %b want 0",
               {w_isel, w_ovf, w_tevt, c_isel, c_ovf, c_tevt});
    end
    cmp++;
    if ({c_page, c_item, c_depth, c_sid} !== 15'd0) begin
      err++;
      $display("FAIL reset_c got %h want 0",
               {c_page, c_item, c_depth, c_sid});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_wrap_items();
    logic [2:0] exp [5];
    exp[0] = 3'd1; exp[1] = 3'd2; exp[2] = 3'd3;
    exp[3] = 3'd4; exp[4] = 3'd0;
    do_reset();
    cnt = 4'd5;
    for (int i = 0; i < 5; i++) begin
      press(DOWN);
      cmp++;
      if (w_item !== exp[i]) begin
        err++;
        $display("FAIL wrap_down%0d got %0d want %0d",
                 i, w_item, exp[i]);
      end
    end
    press(UP);
    cmp++;
    if (w_item !== 3'd4) begin
      err++;
      $display("FAIL wrap_up got %0d want 4", w_item);
    end
  endtask

  task automatic test_clamp();
    logic [2:0] exp [4];
    exp[0] = 3'd1; exp[1] = 3'd2; exp[2] = 3'd2; exp[3] = 3'd2;
    do_reset();
    cnt = 4'd3;
    for (int i = 0; i < 4; i++) begin
      press(DOWN);
      cmp++;
      if (c_item !== exp[i]) begin
        err++;
        $display("FAIL clamp_down%0d got %0d want %0d",
                 i, c_item, exp[i]);
      end
    end
    press(LEFT);
    cmp++;
    if (c_page !== 3'd0) begin
      err++;
      $display("FAIL clamp_left got %0d want 0", c_page);
    end
    cmp++;
    if ({w_page, w_item} !== {3'd7, 3'd0}) begin
      err++;
      $display("FAIL wrap_left got p%0d i%0d want p7 i0",
               w_page, w_item);
    end
    press(RGHT);
    cmp++;
    if (w_page !== 3'd0) begin
      err++;
      $display("FAIL wrap_right got %0d want 0", w_page);
    end
  endtask

  task automatic test_descend();
    do_reset();
    cnt = 4'd5;
    press(RGHT);
    press(RGHT);
    press(DOWN);
    ch_en = 1'b1;
    ch_pg = 3'd6;
    @(negedge clk);
    b_sel = 1'b1;
    @(negedge clk);
    b_sel = 1'b0;
    cmp++;
    if ({w_page, w_item, w_depth, w_isel} !== {3'd6, 3'd0, 3'd1, 1'b0}) begin
      err++;
      $display("FAIL descend got p%0d i%0d d%0d s%0d want p6 i0 d1 s0",
               w_page, w_item, w_depth, w_isel);
    end
    ch_en = 1'b0;
    press(DOWN);
    press(DOWN);
    cmp++;
    if (w_item !== 3'd2) begin
      err++;
      $display("FAIL child_items got %0d want 2", w_item);
    end
    press(BACK);
    cmp++;
    if ({w_page, w_item, w_depth} !== {3'd2, 3'd1, 3'd0}) begin
      err++;
      $display("FAIL back got p%0d i%0d d%0d want p2 i1 d0",
               w_page, w_item, w_depth);
    end
  endtask

  task automatic test_leaf();
    do_reset();
    cnt = 4'd5;
    press(RGHT);
    press(RGHT);
    press(RGHT);
    press(DOWN);
    press(DOWN);
    press(SEL);
    cmp++;
    if ({w_sid, w_isel} !== {6'h1A, 1'b1}) begin
      err++;
      $display("FAIL leaf_sel got id%h s%0d want id1a s1",
               w_sid, w_isel);
    end
    idle(1);
    cmp++;
    if ({w_sid, w_isel, w_page, w_item} !== {6'h1A, 1'b0, 3'd3, 3'd2}) begin
      err++;
      $display("FAIL leaf_after got id%h s%0d p%0d i%0d want id1a s0 p3 i2",
               w_sid, w_isel, w_page, w_item);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    cnt = 4'd5;
    ch_en = 1'b1;
    ch_pg = 3'd5;
    for (int i = 0; i < 4; i++) press(SEL);
    cmp++;
    if ({w_depth, w_page} !== {3'd4, 3'd5}) begin
      err++;
      $display("FAIL deep got d%0d p%0d want d4 p5", w_depth, w_page);
    end
    press(SEL);
    cmp++;
    if ({w_ovf, w_depth, w_isel} !== {1'b1, 3'd4, 1'b0}) begin
      err++;
      $display("FAIL ovf got o%0d d%0d s%0d want o1 d4 s0",
               w_ovf, w_depth, w_isel);
    end
    idle(1);
    cmp++;
    if (w_ovf !== 1'b0) begin
      err++;
      $display("FAIL ovf_pulse got %0d want 0", w_ovf);
    end
    ch_en = 1'b0;
    for (int i = 0; i < 4; i++) press(BACK);
    press(BACK);
    cmp++;
    if ({w_depth, w_page, w_item} !== 9'd0) begin
      err++;
      $display("FAIL back_root got d%0d p%0d i%0d want 0/0/0",
               w_depth, w_page, w_item);
    end
  endtask

  task automatic test_shrink();
    do_reset();
    cnt = 4'd5;
    for (int i = 0; i < 4; i++) press(DOWN);
    cnt = 4'd2;
    idle(1);
    cmp++;
    if ({w_item, c_item} !== {3'd4, 3'd4}) begin
      err++;
      $display("FAIL shrink_hold got w%0d c%0d want 4 4", w_item, c_item);
    end
    press(DOWN);
    cmp++;
    if ({w_item, c_item} !== {3'd0, 3'd1}) begin
      err++;
      $display("FAIL shrink_down got w%0d c%0d want 0 1", w_item, c_item);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    cnt = 4'd5;
    ch_en = 1'b1;
    ch_pg = 3'd4;
    press(SEL);
    press(SEL);
    idle(9);
    cmp++;
    if ({w_tevt, w_depth} !== {1'b0, 3'd2}) begin
      err++;
      $display("FAIL to_early got t%0d d%0d want t0 d2", w_tevt, w_depth);
    end
    idle(1);
    cmp++;
    if ({w_tevt, w_page, w_item, w_depth} !== {1'b1, 9'd0}) begin
      err++;
      $display("FAIL to_fire got t%0d p%0d i%0d d%0d want t1 0/0/0",
               w_tevt, w_page, w_item, w_depth);
    end
    idle(1);
    cmp++;
    if (w_tevt !== 1'b0) begin
      err++;
      $display("FAIL to_pulse got %0d want 0", w_tevt);
    end
    press(SEL);
    press(SEL);
    idle(8);
    press(SEL | DOWN);
    cmp++;
    if ({w_tevt, w_depth, w_page, w_item} !== {1'b0, 3'd3, 3'd4, 3'd0}) begin
      err++;
      $display("FAIL to_btn got t%0d d%0d p%0d i%0d want t0 d3 p4 i0",
               w_tevt, w_depth, w_page, w_item);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    cmp++;
    if ({w_page, w_item, w_depth, w_tevt, w_isel} !== 11'd0) begin
      err++;
      $display("FAIL async_rst got p%0d i%0d d%0d want 0/0/0",
               w_page, w_item, w_depth);
    end
    idle(1);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_wrap_items();
    test_clamp();
    test_descend();
    test_leaf();
    test_overflow();
    test_shrink();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end

endmodule
